// File: rtl/cam_spi_slave.sv
// cam_spi_slave: responder side of the 26-bit CPOL=0/CPHA=0 camera SPI register link.
// Latency: miso updates 1 c cycle after the synchronized sck rise (about 3 c after the pin); wr_strobe follows cs rise by about 4 c.
// Backpressure: none; the master owns the pace, and sck half-periods below MIN_HALF c cycles are unsupported.
//
// Ports:
//   c, rst_n          system clock, synchronous active-low reset
//   cs, sck, mosi     SPI inputs from the master, asynchronous to c
//   miso              SPI read data, valid for the master's next sck rise
//   wr_strobe         one-cycle pulse per committed write, with wr_addr / wr_data
//   frame_err_cnt     saturating count of frames with a bit count other than 26
//
// Optional build macro CAM_SPI_SLAVE_FRAME_ERR_EN enables the malformed-frame
// counter and its simulation message; otherwise frame_err_cnt is tied to 0.
module cam_spi_slave #(
  parameter int          ADDR_W   = 9,
  parameter int          NREGS    = 64,
  parameter logic [15:0] CHIP_ID  = 16'h5000,
  parameter int          MIN_HALF = 8
) (
  input  logic              c,
  input  logic              rst_n,
  input  logic              cs,
  input  logic              sck,
  input  logic              mosi,
  output logic              miso,
  output logic              wr_strobe,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [15:0]       wr_data,
  output logic [15:0]       frame_err_cnt
);

  localparam int FRAME_W = ADDR_W + 17;   // {addr, wr, data[15:0]}
  localparam int IDX_W   = $clog2(NREGS);

  // miso is registered one cycle after the synchronized rise; the 2-flop
  // synchronizer plus that register need at least a few c cycles per half-period.
  if (MIN_HALF < 4) begin : g_min_half_chk
    $error("cam_spi_slave: MIN_HALF must be at least 4");
  end

  typedef enum logic [1:0] {S_WAIT_IDLE, S_IDLE, S_SHIFT, S_END} state_t;

  state_t               state_q, state_d;
  logic                 cs_s1_q, cs_s2_q;
  logic                 sck_s1_q, sck_s2_q, sck_prev_q;
  logic                 mosi_s1_q, mosi_s2_q;
  logic [4:0]           cnt_q, cnt_d;
  logic [FRAME_W-1:0]   shift_q, shift_d;
  logic [15:0]          rd_word_q, rd_word_d;
  logic                 pend_q, pend_d;
  logic                 miso_q, miso_d;
  logic                 wr_strobe_q, wr_strobe_d;
  logic [ADDR_W-1:0]    wr_addr_q, wr_addr_d;
  logic [15:0]          wr_data_q, wr_data_d;
  logic                 reg_we;
  logic [15:0]          regs_q [NREGS];

  logic                 sck_rise, sck_fall;
  logic [ADDR_W-1:0]    rd_addr, fr_addr;
  logic [15:0]          rd_val;

  assign sck_rise = sck_s2_q & ~sck_prev_q;
  assign sck_fall = ~sck_s2_q & sck_prev_q;

  // At the (ADDR_W+1)th rise the address sits in the low shift bits and the
  // wr flag is the bit being shifted in on that same rise.
  assign rd_addr = shift_q[ADDR_W-1:0];
  assign fr_addr = shift_q[FRAME_W-1 -: ADDR_W];

  always_comb begin
    rd_val = '0;
    if (!mosi_s2_q) begin
      if (rd_addr == '0)
        rd_val = CHIP_ID;
      else if (32'(rd_addr) < NREGS)
        rd_val = regs_q[rd_addr[IDX_W-1:0]];
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    shift_d     = shift_q;
    rd_word_d   = rd_word_q;
    pend_d      = pend_q;
    miso_d      = miso_q;
    wr_strobe_d = 1'b0;
    wr_addr_d   = wr_addr_q;
    wr_data_d   = wr_data_q;
    reg_we      = 1'b0;
    case (state_q)
      S_WAIT_IDLE: begin
        miso_d = 1'b0;
        if (cs_s2_q) state_d = S_IDLE;
      end
      S_IDLE: begin
        miso_d = 1'b0;
        // cs is known high on entry, so a low here is the falling edge.
        if (!cs_s2_q) begin
          state_d = S_SHIFT;
          cnt_d   = '0;
          shift_d = '0;
          pend_d  = 1'b0;
        end
      end
      S_SHIFT: begin
        if (sck_rise) begin
          shift_d = {shift_q[FRAME_W-2:0], mosi_s2_q};
          if (cnt_q != 5'd31) cnt_d = cnt_q + 5'd1;
          pend_d = 1'b1;
          // rd_word is used as a shift register so its MSB is always the next bit.
          if (cnt_d == 5'(ADDR_W + 1)) begin
            rd_word_d = rd_val;
            miso_d    = rd_val[15];
          end else if (cnt_d > 5'(ADDR_W + 1) && cnt_d < 5'(FRAME_W)) begin
            rd_word_d = {rd_word_q[14:0], 1'b0};
            miso_d    = rd_word_q[14];
          end else begin
            miso_d = 1'b0;
          end
        end else if (sck_fall) begin
          pend_d = 1'b0;
        end
        // A rise in the same cycle as cs deassert is counted above first.
        if (cs_s2_q) begin
          state_d = S_END;
          miso_d  = 1'b0;
        end
      end
      S_END: begin
        miso_d  = 1'b0;
        state_d = S_IDLE;
        if (cnt_q == 5'(FRAME_W) && !pend_q && shift_q[16]) begin
          wr_strobe_d = 1'b1;
          wr_addr_d   = fr_addr;
          wr_data_d   = shift_q[15:0];
          reg_we      = (fr_addr != '0) && (32'(fr_addr) < NREGS);
        end
      end
      default: state_d = S_WAIT_IDLE;
    endcase
  end

  always_ff @(posedge c) begin
    if (!rst_n) begin
      state_q     <= S_WAIT_IDLE;
      // cs sync resets low so WAIT_IDLE only leaves on a real deassert.
      cs_s1_q     <= 1'b0;
      cs_s2_q     <= 1'b0;
      sck_s1_q    <= 1'b0;
      sck_s2_q    <= 1'b0;
      sck_prev_q  <= 1'b0;
      mosi_s1_q   <= 1'b0;
      mosi_s2_q   <= 1'b0;
      cnt_q       <= '0;
      shift_q     <= '0;
      rd_word_q   <= '0;
      pend_q      <= 1'b0;
      miso_q      <= 1'b0;
      wr_strobe_q <= 1'b0;
      wr_addr_q   <= '0;
      wr_data_q   <= '0;
    end else begin
      state_q     <= state_d;
      cs_s1_q     <= cs;
      cs_s2_q     <= cs_s1_q;
      sck_s1_q    <= sck;
      sck_s2_q    <= sck_s1_q;
      sck_prev_q  <= sck_s2_q;
      mosi_s1_q   <= mosi;
      mosi_s2_q   <= mosi_s1_q;
      cnt_q       <= cnt_d;
      shift_q     <= shift_d;
      rd_word_q   <= rd_word_d;
      pend_q      <= pend_d;
      miso_q      <= miso_d;
      wr_strobe_q <= wr_strobe_d;
      wr_addr_q   <= wr_addr_d;
      wr_data_q   <= wr_data_d;
    end
  end

  // Entry 0 is never written; address 0 reads CHIP_ID instead.
  always_ff @(posedge c) begin
    if (!rst_n) begin
      for (int i = 0; i < NREGS; i++) regs_q[i] <= '0;
    end else if (reg_we) begin
      regs_q[shift_q[17 +: IDX_W]] <= shift_q[15:0];
    end
  end

  assign miso      = miso_q;
  assign wr_strobe = wr_strobe_q;
  assign wr_addr   = wr_addr_q;
  assign wr_data   = wr_data_q;

`ifdef CAM_SPI_SLAVE_FRAME_ERR_EN
  logic        err_inc;
  logic [15:0] err_q;

  assign err_inc = (state_q == S_END) && (cnt_q != 5'(FRAME_W));

  always_ff @(posedge c) begin
    if (!rst_n)
      err_q <= '0;
    else if (err_inc && err_q != 16'hFFFF)
      err_q <= err_q + 16'd1;
  end

`ifndef SYNTHESIS
  always_ff @(posedge c) begin
    if (rst_n && err_inc)
      $display("cam_spi_slave: malformed frame with %0d sck rises", cnt_q);
  end
`endif

  assign frame_err_cnt = err_q;
`else
  assign frame_err_cnt = '0;
`endif

endmodule

// File: tb/tb_cam_spi_slave.sv
// tb_cam_spi_slave: directed register read/write frames against cam_spi_slave.
// Latency: frames are timed by the bench's SPI master model, all in c cycles.
// Backpressure: none; outputs are sampled on the falling edge of c.
module tb_cam_spi_slave;

  logic        c = 1'b0;
  logic        rst_n = 1'b0;
  logic        cs = 1'b1;
  logic        sck = 1'b0;
  logic        mosi = 1'b0;
  logic        miso;
  logic        wr_strobe;
  logic [8:0]  wr_addr;
  logic [15:0] wr_data;
  logic [15:0] frame_err_cnt;

  int n_cmp = 0;
  int n_bad = 0;

  int          strobe_cnt = 0;
  logic [8:0]  last_addr  = '0;
  logic [15:0] last_data  = '0;

  logic [25:0] rxd;
  logic [25:0] rxd2;
  logic [25:0] rxd3;
  int          sc0;

`ifdef CAM_SPI_SLAVE_FRAME_ERR_EN
  localparam logic [15:0] ERR_AFTER_TRUNC = 16'd1;
`else
  localparam logic [15:0] ERR_AFTER_TRUNC = 16'd0;
`endif

  cam_spi_slave dut (
    .c             (c),
    .rst_n         (rst_n),
    .cs            (cs),
    .sck           (sck),
    .mosi          (mosi),
    .miso          (miso),
    .wr_strobe     (wr_strobe),
    .wr_addr       (wr_addr),
    .wr_data       (wr_data),
    .frame_err_cnt (frame_err_cnt)
  );

  always #5 c = ~c;

  always @(negedge c) begin
    if (wr_strobe) begin
      strobe_cnt++;
      last_addr = wr_addr;
      last_data = wr_data;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic wait_clk(input int n);
    repeat (n) @(negedge c);
  endtask

  function automatic logic [25:0] mk(input logic [8:0] a, input logic w, input logic [15:0] d);
    return {a, w, d};
  endfunction

  // Master model: drives mosi in the low phase, samples miso just before each rise.
  // rst_at > 0 pulses rst_n low for 2 cycles after that many rises.
  task automatic spi_frame(input logic [25:0] txd, input int nrise, input int half,
                           input int gap, input int rst_at, output logic [25:0] rx);
    rx   = '0;
    cs   = 1'b0;
    mosi = 1'b0;
    wait_clk(half);
    for (int i = 0; i < nrise; i++) begin
      mosi = txd[25-i];
      wait_clk(half);
      rx  = {rx[24:0], miso};
      sck = 1'b1;
      wait_clk(half);
      sck = 1'b0;
      if (i + 1 == rst_at) begin
        rst_n = 1'b0;
        wait_clk(2);
        rst_n = 1'b1;
      end
    end
    wait_clk(half);
    cs = 1'b1;
    wait_clk(gap);
  endtask

  initial begin
    wait_clk(5);
    rst_n = 1'b1;
    wait_clk(1);
    check("rst_miso",      32'(miso),          32'd0);
    check("rst_wr_strobe", 32'(wr_strobe),     32'd0);
    check("rst_wr_addr",   32'(wr_addr),       32'd0);
    check("rst_wr_data",   32'(wr_data),       32'd0);
    check("rst_err_cnt",   32'(frame_err_cnt), 32'd0);
    wait_clk(5);

    // Chip ID read at a slow sck.
    spi_frame(mk(9'h000, 1'b0, 16'h0000), 26, 50, 20, 0, rxd);
    check("rd_chip_id",    32'(rxd[15:0]), 32'h5000);
    check("rd_no_strobe",  32'(strobe_cnt), 32'd0);

    // Write then read back 0x020.
    spi_frame(mk(9'h020, 1'b1, 16'hBEEF), 26, 20, 20, 0, rxd);
    check("wr_miso_zero",  32'(rxd), 32'd0);
    check("wr20_strobes",  32'(strobe_cnt), 32'd1);
    check("wr20_addr",     32'(last_addr), 32'h020);
    check("wr20_data",     32'(last_data), 32'hBEEF);
    spi_frame(mk(9'h020, 1'b0, 16'h0000), 26, 20, 20, 0, rxd);
    check("rd20",          32'(rxd[15:0]), 32'hBEEF);
    check("rd20_strobes",  32'(strobe_cnt), 32'd1);

    // Writes to the read-only and unimplemented addresses still strobe.
    spi_frame(mk(9'h000, 1'b1, 16'h1234), 26, 20, 20, 0, rxd);
    check("wr0_strobes",   32'(strobe_cnt), 32'd2);
    check("wr0_addr",      32'(last_addr), 32'h000);
    check("wr0_data",      32'(last_data), 32'h1234);
    spi_frame(mk(9'h100, 1'b1, 16'h1234), 26, 20, 20, 0, rxd);
    check("wr100_strobes", 32'(strobe_cnt), 32'd3);
    check("wr100_addr",    32'(last_addr), 32'h100);
    spi_frame(mk(9'h000, 1'b0, 16'h0000), 26, 20, 20, 0, rxd);
    check("rd0_after_wr",  32'(rxd[15:0]), 32'h5000);
    spi_frame(mk(9'h100, 1'b0, 16'h0000), 26, 20, 20, 0, rxd);
    check("rd100",         32'(rxd[15:0]), 32'h0000);

    // Truncated write: 12 rises only.
    spi_frame(mk(9'h005, 1'b1, 16'hA5A5), 12, 20, 20, 0, rxd);
    check("trunc_strobes", 32'(strobe_cnt), 32'd3);
    check("trunc_err_cnt", 32'(frame_err_cnt), 32'(ERR_AFTER_TRUNC));
    spi_frame(mk(9'h005, 1'b0, 16'h0000), 26, 20, 20, 0, rxd);
    check("rd5_unchanged", 32'(rxd[15:0]), 32'h0000);

    // Reset mid-frame after 8 rises; remainder of the frame must be ignored.
    spi_frame(mk(9'h007, 1'b1, 16'h5A5A), 26, 20, 20, 8, rxd);
    check("rstmid_strobes", 32'(strobe_cnt), 32'd3);
    check("rstmid_err_cnt", 32'(frame_err_cnt), 32'd0);
    spi_frame(mk(9'h007, 1'b0, 16'h0000), 26, 20, 20, 0, rxd);
    check("rd7_ignored",   32'(rxd[15:0]), 32'h0000);
    spi_frame(mk(9'h007, 1'b1, 16'h5A5A), 26, 20, 20, 0, rxd);
    check("wr7_strobes",   32'(strobe_cnt), 32'd4);
    check("wr7_addr",      32'(last_addr), 32'h007);
    check("wr7_data",      32'(last_data), 32'h5A5A);
    spi_frame(mk(9'h007, 1'b0, 16'h0000), 26, 20, 20, 0, rxd);
    check("rd7",           32'(rxd[15:0]), 32'h5A5A);
    check("rd20_cleared",  32'(frame_err_cnt), 32'd0);

    // Back-to-back frames, 2 c of cs high, sck half-period 8.
    sc0 = strobe_cnt;
    spi_frame(mk(9'h003, 1'b1, 16'hC3A5), 26, 8, 2, 0, rxd);
    spi_frame(mk(9'h003, 1'b0, 16'h0000), 26, 8, 2, 0, rxd2);
    spi_frame(mk(9'h000, 1'b0, 16'h0000), 26, 8, 20, 0, rxd3);
    check("b2b_strobes",   32'(strobe_cnt - sc0), 32'd1);
    check("b2b_wr_addr",   32'(last_addr), 32'h003);
    check("b2b_wr_data",   32'(last_data), 32'hC3A5);
    check("b2b_rd3",       32'(rxd2), 32'h0000C3A5);
    check("b2b_rd0",       32'(rxd3), 32'h00005000);
    check("idle_miso",     32'(miso), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
